// File: rtl/npc_ras_unit.sv
// rtl/npc_ras_unit.sv - next-PC generator with a circular return-address stack
// Holds the fetch PC and predicts JR $ra targets for misprediction statistics.
module npc_ras_unit #(
    parameter int          AW        = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          LINK_OFF  = 4,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [AW-1:0]    id_pcplus4,
    input  logic [25:0]      id_instr25to0,
    input  logic [AW-1:0]    id_imm_ext,
    input  logic             id_is_branch,
    input  logic             id_cmp_taken,
    input  logic             id_is_j,
    input  logic             id_is_jal,
    input  logic             id_is_jr,
    input  logic             id_jr_is_ra,
    input  logic [AW-1:0]    id_rs_val,
    output logic [AW-1:0]    pc_o,
    output logic [AW-1:0]    pcplus4_o,
    output logic [AW-1:0]    ras_top_o,
    output logic             ras_empty_o,
    output logic             jr_mispred_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int            PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(RAS_DEPTH);
    localparam logic [AW-1:0] LOW28    = AW'(28'hFFF_FFFF);
    localparam logic [AW-1:0] PC_RST   = AW'(RESET_PC);

    logic [AW-1:0]    pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      occ_q, occ_d;
    logic [AW-1:0]    ras_q [RAS_DEPTH];
    logic [AW-1:0]    ras_d [RAS_DEPTH];
    logic             mispred_q, mispred_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [AW-1:0] pcplus4;
    logic [AW-1:0] branch_tgt;
    logic [AW-1:0] jump_tgt;
    logic [AW-1:0] link_val;
    logic [AW-1:0] ras_top;
    logic [PW-1:0] ptr_inc;
    logic          ras_empty;
    logic          push_req;
    logic          pop_req;

    always_comb begin
        pcplus4    = pc_q + AW'(4);
        branch_tgt = id_pcplus4 + (id_imm_ext << 2);
        jump_tgt   = (id_pcplus4 & ~LOW28) | AW'({id_instr25to0, 2'b00});
        link_val   = id_pcplus4 + AW'(LINK_OFF);
        ras_empty  = (occ_q == '0);
        ras_top    = ras_empty ? '0 : ras_q[ptr_q];
        ptr_inc    = ptr_q + PW'(1);
        push_req   = id_is_jal;
        pop_req    = id_is_jr & id_jr_is_ra;
    end

    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        occ_d     = occ_q;
        ras_d     = ras_q;
        mispred_d = 1'b0;
        cnt_d     = cnt_q;
        if (!stall) begin
            if (id_is_jr)
                pc_d = id_rs_val;
            else if (id_is_j)
                pc_d = jump_tgt;
            else if (id_is_branch && id_cmp_taken)
                pc_d = branch_tgt;
            else
                pc_d = pcplus4;

            // JALR $31,$31 swaps the top in place; with an empty stack it is a plain push.
            if (push_req && pop_req && !ras_empty) begin
                ras_d[ptr_q] = link_val;
            end else if (push_req) begin
                ptr_d          = ptr_inc;
                ras_d[ptr_inc] = link_val;
                if (occ_q != OCC_FULL)
                    occ_d = occ_q + 1'b1;
            end else if (pop_req && !ras_empty) begin
                ptr_d = ptr_q - PW'(1);
                occ_d = occ_q - 1'b1;
            end

            if (pop_req && (ras_empty || (ras_top != id_rs_val))) begin
                mispred_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_RST;
            ptr_q     <= '0;
            occ_q     <= '0;
            mispred_q <= 1'b0;
            cnt_q     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            ptr_q     <= ptr_d;
            occ_q     <= occ_d;
            mispred_q <= mispred_d;
            cnt_q     <= cnt_d;
            ras_q     <= ras_d;
        end
    end

    assign pc_o          = pc_q;
    assign pcplus4_o     = pcplus4;
    assign ras_top_o     = ras_top;
    assign ras_empty_o   = ras_empty;
    assign jr_mispred_o  = mispred_q;
    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// tb/tb_npc_ras_unit.sv - directed self-checking bench for npc_ras_unit
module tb_npc_ras_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] id_pcplus4 = '0;
    logic [25:0] id_instr25to0 = '0;
    logic [31:0] id_imm_ext = '0;
    logic        id_is_branch = 1'b0;
    logic        id_cmp_taken = 1'b0;
    logic        id_is_j = 1'b0;
    logic        id_is_jal = 1'b0;
    logic        id_is_jr = 1'b0;
    logic        id_jr_is_ra = 1'b0;
    logic [31:0] id_rs_val = '0;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;
    logic [31:0] ras_top_o;
    logic        ras_empty_o;
    logic        jr_mispred_o;
    logic [15:0] mispred_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    npc_ras_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .id_pcplus4    (id_pcplus4),
        .id_instr25to0 (id_instr25to0),
        .id_imm_ext    (id_imm_ext),
        .id_is_branch  (id_is_branch),
        .id_cmp_taken  (id_cmp_taken),
        .id_is_j       (id_is_j),
        .id_is_jal     (id_is_jal),
        .id_is_jr      (id_is_jr),
        .id_jr_is_ra   (id_jr_is_ra),
        .id_rs_val     (id_rs_val),
        .pc_o          (pc_o),
        .pcplus4_o     (pcplus4_o),
        .ras_top_o     (ras_top_o),
        .ras_empty_o   (ras_empty_o),
        .jr_mispred_o  (jr_mispred_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; id_pcplus4 = '0; id_instr25to0 = '0; id_imm_ext = '0;
        id_is_branch = 0; id_cmp_taken = 0; id_is_j = 0; id_is_jal = 0;
        id_is_jr = 0; id_jr_is_ra = 0; id_rs_val = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        do_reset();
        n_checks++; if (pc_o !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h3000); end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", ras_empty_o); end
        n_checks++; if (ras_top_o !== 32'h0) begin n_fail++; $display("FAIL reset_top: got %h expected 0", ras_top_o); end
        n_checks++; if (jr_mispred_o !== 1'b0) begin n_fail++; $display("FAIL reset_mispred: got %b expected 0", jr_mispred_o); end
        n_checks++; if (mispred_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", mispred_cnt_o); end
        exp_pc = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = exp_pc + 4;
            n_checks++; if (pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc_o, exp_pc); end
            n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL seq_empty[%0d]: got %b expected 1", i, ras_empty_o); end
        end
        n_checks++; if (pcplus4_o !== 32'h3010) begin n_fail++; $display("FAIL seq_pcplus4: got %h expected %h", pcplus4_o, 32'h3010); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            repeat (4) step();
            n_checks++; if (pc_o !== 32'h3010) begin n_fail++; $display("FAIL br_start[%0d]: got %h expected %h", t, pc_o, 32'h3010); end
            id_is_branch = 1; id_cmp_taken = (t == 1); id_imm_ext = 32'hFFFF_FFFC; id_pcplus4 = 32'h3010;
            step();
            clear_inputs();
            if (t == 0) begin
                n_checks++; if (pc_o !== 32'h3014) begin n_fail++; $display("FAIL br_not_taken: got %h expected %h", pc_o, 32'h3014); end
            end else begin
                n_checks++; if (pc_o !== 32'h3000) begin n_fail++; $display("FAIL br_taken: got %h expected %h", pc_o, 32'h3000); end
            end
        end
    endtask

    task automatic test_jump();
        id_is_j = 1; id_instr25to0 = 26'h0000C40; id_pcplus4 = 32'h1000_0010;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h1000_3100) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", pc_o, 32'h1000_3100); end
        id_is_jr = 1; id_rs_val = 32'h0000_ABC0; id_is_j = 1; id_instr25to0 = 26'h1;
        id_is_branch = 1; id_cmp_taken = 1; id_imm_ext = 32'h10; id_pcplus4 = 32'h2000;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h0000_ABC0) begin n_fail++; $display("FAIL prio_jr: got %h expected %h", pc_o, 32'h0000_ABC0); end
        id_is_j = 1; id_instr25to0 = 26'h100; id_is_branch = 1; id_cmp_taken = 1; id_pcplus4 = 32'h2000;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h0000_0400) begin n_fail++; $display("FAIL prio_j: got %h expected %h", pc_o, 32'h0000_0400); end
    endtask

    task automatic test_jal_jr();
        id_is_j = 1; id_is_jal = 1; id_instr25to0 = 26'h0000C00; id_pcplus4 = 32'h3008;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h3000) begin n_fail++; $display("FAIL jal_pc: got %h expected %h", pc_o, 32'h3000); end
        n_checks++; if (ras_top_o !== 32'h300C) begin n_fail++; $display("FAIL jal_top: got %h expected %h", ras_top_o, 32'h300C); end
        n_checks++; if (ras_empty_o !== 1'b0) begin n_fail++; $display("FAIL jal_empty: got %b expected 0", ras_empty_o); end
        id_is_jr = 1; id_jr_is_ra = 1; id_rs_val = 32'h300C;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h300C) begin n_fail++; $display("FAIL jr_pc: got %h expected %h", pc_o, 32'h300C); end
        n_checks++; if (jr_mispred_o !== 1'b0) begin n_fail++; $display("FAIL jr_mispred: got %b expected 0", jr_mispred_o); end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL jr_empty: got %b expected 1", ras_empty_o); end
        n_checks++; if (mispred_cnt_o !== 16'h0) begin n_fail++; $display("FAIL jr_cnt: got %h expected 0", mispred_cnt_o); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_top;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            id_is_jal = 1; id_pcplus4 = 32'h4000 + 32'(i * 16);
            step();
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            exp_top = (i < 4) ? 32'h4044 - 32'(i * 16) : 32'h0;
            n_checks++; if (ras_top_o !== exp_top) begin n_fail++; $display("FAIL ovf_top[%0d]: got %h expected %h", i, ras_top_o, exp_top); end
            id_is_jr = 1; id_jr_is_ra = 1; id_rs_val = 32'h4044 - 32'(i * 16);
            step();
            clear_inputs();
            n_checks++; if (jr_mispred_o !== (i == 4)) begin n_fail++; $display("FAIL ovf_mispred[%0d]: got %b expected %b", i, jr_mispred_o, (i == 4)); end
            n_checks++; if (mispred_cnt_o !== ((i == 4) ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL ovf_cnt[%0d]: got %0d expected %0d", i, mispred_cnt_o, (i == 4) ? 1 : 0); end
        end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b expected 1", ras_empty_o); end
        step();
        n_checks++; if (jr_mispred_o !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_len: got %b expected 0", jr_mispred_o); end
        n_checks++; if (mispred_cnt_o !== 16'd1) begin n_fail++; $display("FAIL ovf_cnt_hold: got %0d expected 1", mispred_cnt_o); end
    endtask

    task automatic test_back_to_back();
        id_is_jal = 1; id_pcplus4 = 32'h5000;
        step();
        clear_inputs();
        id_is_jal = 1; id_is_jr = 1; id_jr_is_ra = 1; id_pcplus4 = 32'h6000; id_rs_val = 32'h5004;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h5004) begin n_fail++; $display("FAIL jalr_pc: got %h expected %h", pc_o, 32'h5004); end
        n_checks++; if (ras_top_o !== 32'h6004) begin n_fail++; $display("FAIL jalr_top: got %h expected %h", ras_top_o, 32'h6004); end
        n_checks++; if (jr_mispred_o !== 1'b0) begin n_fail++; $display("FAIL jalr_mispred: got %b expected 0", jr_mispred_o); end
        id_is_jr = 1; id_jr_is_ra = 1; id_rs_val = 32'h1234;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h1234) begin n_fail++; $display("FAIL wrong_pc: got %h expected %h", pc_o, 32'h1234); end
        n_checks++; if (jr_mispred_o !== 1'b1) begin n_fail++; $display("FAIL wrong_mispred: got %b expected 1", jr_mispred_o); end
        n_checks++; if (mispred_cnt_o !== 16'd2) begin n_fail++; $display("FAIL wrong_cnt: got %0d expected 2", mispred_cnt_o); end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL wrong_empty: got %b expected 1", ras_empty_o); end
    endtask

    task automatic test_stall_reset();
        id_is_jal = 1; id_pcplus4 = 32'h7000;
        step();
        clear_inputs();
        n_checks++; if (pc_o !== 32'h1238) begin n_fail++; $display("FAIL stall_pre_pc: got %h expected %h", pc_o, 32'h1238); end
        stall = 1; id_is_jal = 1; id_is_j = 1; id_instr25to0 = 26'h55; id_pcplus4 = 32'h8000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc_o !== 32'h1238) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc_o, 32'h1238); end
            n_checks++; if (ras_top_o !== 32'h7004) begin n_fail++; $display("FAIL stall_top[%0d]: got %h expected %h", i, ras_top_o, 32'h7004); end
        end
        id_is_jal = 0; id_is_j = 0; id_is_jr = 1; id_jr_is_ra = 1; id_rs_val = 32'hBAD0;
        step();
        n_checks++; if (jr_mispred_o !== 1'b0) begin n_fail++; $display("FAIL stall_mispred: got %b expected 0", jr_mispred_o); end
        n_checks++; if (mispred_cnt_o !== 16'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 2", mispred_cnt_o); end
        n_checks++; if (ras_empty_o !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b expected 0", ras_empty_o); end
        id_is_jr = 0; id_jr_is_ra = 0; id_is_j = 1; id_instr25to0 = 26'h123;
        rst = 1;
        step();
        rst = 0;
        clear_inputs();
        n_checks++; if (pc_o !== 32'h3000) begin n_fail++; $display("FAIL rst_redirect_pc: got %h expected %h", pc_o, 32'h3000); end
        n_checks++; if (mispred_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_redirect_cnt: got %0d expected 0", mispred_cnt_o); end
        n_checks++; if (ras_empty_o !== 1'b1) begin n_fail++; $display("FAIL rst_redirect_empty: got %b expected 1", ras_empty_o); end
        n_checks++; if (ras_top_o !== 32'h0) begin n_fail++; $display("FAIL rst_redirect_top: got %h expected 0", ras_top_o); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_jal_jr();
        test_ras_overflow();
        test_back_to_back();
        test_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
